// File: rtl/npc_pkg.sv
// Shared encodings, FSM states and immediate decoding for the multi-cycle NPC core.
package npc_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {FETCH, EXEC, WB, HALT} state_e;

    typedef enum logic [1:0] {IMM_I, IMM_U, IMM_J} imm_fmt_e;

    function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_U:   imm = {inst[31:12], 12'h000};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/regfile_np.sv
// Architectural register file: two combinational read ports, one synchronous write port.
module regfile_np #(
    parameter int NREGS = 32,
    parameter int W     = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [W-1:0]  rdata1,
    output logic [W-1:0]  rdata2,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata
);

    logic [NREGS-1:0][W-1:0] regs_q, regs_d;

    // x0 is never written, so its slot stays at the cleared value
    always_comb begin
        regs_d = regs_q;
        if (we && waddr != '0) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '0;
        else        regs_q <= regs_d;
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/npc_mc.sv
// Multi-cycle RV32I-subset core: FETCH over valid/ready, EXEC, WB; halts on ebreak or illegal op.
module npc_mc
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        if_valid,
    output logic [31:0] if_addr,
    input  logic        if_ready,
    input  logic [31:0] if_inst,
    output logic [31:0] pc,
    output logic        commit,
    output logic [31:0] alu_result,
    output logic        halt,
    output logic        trap
);

    localparam int AW = $clog2(NREGS);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, res_q, res_d, npc_q, npc_d;
    logic        halt_q, halt_d, trap_q, trap_d;

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val, exe_res, exe_npc;
    logic        legal, is_ebreak, rd_used, rs1_used, rs2_used;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    regfile_np #(.NREGS(NREGS), .W(32)) u_rf (
        .clk    (clk),
        .rst_n  (rst),
        .raddr1 (rs1[AW-1:0]),
        .raddr2 (rs2[AW-1:0]),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .we     (state_q == WB),
        .waddr  (rd[AW-1:0]),
        .wdata  (res_q)
    );

    always_comb begin
        exe_res   = '0;
        exe_npc   = pc_q + 32'd4;
        legal     = 1'b1;
        is_ebreak = 1'b0;
        rd_used   = 1'b1;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        case (opcode)
            OP_IMM: begin
                legal    = (funct3 == 3'b000);
                rs1_used = 1'b1;
                exe_res  = rs1_val + imm_gen(ir_q, IMM_I);
            end
            OP: begin
                legal    = (funct3 == 3'b000) && (funct7 == 7'b0000000);
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                exe_res  = rs1_val + rs2_val;
            end
            LUI:   exe_res = imm_gen(ir_q, IMM_U);
            AUIPC: exe_res = pc_q + imm_gen(ir_q, IMM_U);
            JAL: begin
                exe_res = pc_q + 32'd4;
                exe_npc = pc_q + imm_gen(ir_q, IMM_J);
            end
            JALR: begin
                legal    = (funct3 == 3'b000);
                rs1_used = 1'b1;
                exe_res  = pc_q + 32'd4;
                exe_npc  = (rs1_val + imm_gen(ir_q, IMM_I)) & ~32'h1;
            end
            SYSTEM: begin
                rd_used   = 1'b0;
                is_ebreak = (ir_q == EBREAK);
                legal     = is_ebreak;
            end
            default: begin
                legal   = 1'b0;
                rd_used = 1'b0;
            end
        endcase
        // RV32E: only fields the instruction actually uses can fault
        if (NREGS == 16 && ((rd_used && rd[4]) || (rs1_used && rs1[4]) || (rs2_used && rs2[4])))
            legal = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        res_d   = res_q;
        npc_d   = npc_q;
        halt_d  = halt_q;
        trap_d  = trap_q;
        case (state_q)
            FETCH: begin
                if (if_ready) begin
                    ir_d    = if_inst;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!legal) begin
                    trap_d  = 1'b1;
                    halt_d  = 1'b1;
                    state_d = HALT;
                end else if (is_ebreak) begin
                    halt_d  = 1'b1;
                    state_d = HALT;
                end else begin
                    res_d   = exe_res;
                    npc_d   = exe_npc;
                    state_d = WB;
                end
            end
            WB: begin
                pc_d    = npc_q;
                state_d = FETCH;
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            res_q   <= '0;
            npc_q   <= '0;
            halt_q  <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            res_q   <= res_d;
            npc_q   <= npc_d;
            halt_q  <= halt_d;
            trap_q  <= trap_d;
        end
    end

    // res_q is loaded on entry to WB, so alu_result is already valid during the commit pulse
    assign if_valid   = (state_q == FETCH);
    assign if_addr    = pc_q;
    assign pc         = pc_q;
    assign commit     = (state_q == WB);
    assign alu_result = res_q;
    assign halt       = halt_q;
    assign trap       = trap_q;

endmodule

// File: tb/tb_npc_mc.sv
// Randomized scoreboard bench for npc_mc with an instruction-level reference model.
module tb_npc_mc;

    localparam logic [31:0] RPC      = 32'h8000_0000;
    localparam logic [31:0] EBRK     = 32'h0010_0073;
    localparam logic [31:0] ADDI_X5  = {12'd3, 5'd0, 3'b000, 5'd5, 7'b0010011};
    localparam logic [31:0] ADDI_X20 = {12'd1, 5'd0, 3'b000, 5'd20, 7'b0010011};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_valid, if_ready, commit, halt, trap;
    logic [31:0] if_addr, if_inst, pc, alu_result;
    logic        if_valid16, commit16, halt16, trap16;
    logic [31:0] if_addr16, if_inst16, pc16, alu_result16;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c16   = 0;

    typedef struct packed {logic [31:0] epc; logic [31:0] eres;} exp_t;
    exp_t        sbq[$];
    logic [31:0] mregs[32];
    logic [31:0] mpc;

    npc_mc #(.RESET_PC(RPC), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
        .if_inst(if_inst), .pc(pc), .commit(commit), .alu_result(alu_result),
        .halt(halt), .trap(trap)
    );

    npc_mc #(.RESET_PC(RPC), .NREGS(16)) dut16 (
        .clk(clk), .rst(rst), .if_valid(if_valid16), .if_addr(if_addr16), .if_ready(1'b1),
        .if_inst(if_inst16), .pc(pc16), .commit(commit16), .alu_result(alu_result16),
        .halt(halt16), .trap(trap16)
    );

    assign if_inst16 = (if_addr16 == RPC) ? ADDI_X5 : ADDI_X20;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (!rst) c16 <= 0;
        else if (commit16) c16 <= c16 + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b1 && commit === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_commit: got commit at pc %h expected none", pc);
            end else begin
                e = sbq.pop_front();
                chk("commit_pc", pc, e.epc);
                chk("commit_res", alu_result, e.eres);
            end
        end
    end

    function automatic logic [31:0] sx12(input logic [31:0] v);
        return {{20{v[11]}}, v[11:0]};
    endfunction

    function automatic logic [31:0] sx21(input logic [31:0] v);
        return {{11{v[20]}}, v[20:0]};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        if_ready = 1'b0;
        if_inst = '0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, RPC);
        chk("rst_commit", 32'(commit), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_res", alu_result, 32'd0);
        sbq.delete();
        foreach (mregs[i]) mregs[i] = '0;
        mpc = RPC;
        rst = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] inst, input int stall, output int t0, output int n);
        n = 0;
        @(negedge clk);
        while (if_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        if (if_valid !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout: if_valid %b expected 1", if_valid);
            return;
        end
        chk("if_addr", if_addr, mpc);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_addr", if_addr, mpc);
            chk("stall_commit", 32'(commit), 32'd0);
        end
        if_ready = 1'b1;
        if_inst  = inst;
        @(posedge clk);
        #1;
        if_ready = 1'b0;
        if_inst  = $urandom();
    endtask

    // k: 0 addi, 1 add, 2 lui, 3 auipc, 4 jal, 5 jalr
    task automatic issue(input int k, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input int stall,
                         input bit lat);
        logic [31:0] inst, res, npc, a, b, j;
        int t0, n, w;
        a    = mregs[rs1];
        b    = mregs[rs2];
        npc  = mpc + 32'd4;
        j    = imm & 32'h001F_FFFE;
        case (k)
            0: begin
                inst = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
                res  = a + sx12(imm);
            end
            1: begin
                inst = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
                res  = a + b;
            end
            2: begin
                inst = {imm[19:0], rd, 7'b0110111};
                res  = (imm & 32'h000F_FFFF) << 12;
            end
            3: begin
                inst = {imm[19:0], rd, 7'b0010111};
                res  = mpc + ((imm & 32'h000F_FFFF) << 12);
            end
            4: begin
                inst = {j[20], j[10:1], j[11], j[19:12], rd, 7'b1101111};
                res  = mpc + 32'd4;
                npc  = mpc + sx21(j);
            end
            default: begin
                inst = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
                res  = mpc + 32'd4;
                npc  = (a + sx12(imm)) & ~32'h1;
            end
        endcase
        sbq.push_back('{epc: mpc, eres: res});
        fetch(inst, stall, t0, n);
        if (rd != 5'd0) mregs[rd] = res;
        mpc = npc;
        if (lat) begin
            chk("fetch_wait", 32'(n), 32'd0);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (commit !== 1'b1 && w < 20);
            chk("latency", 32'(cyc - t0), 32'(stall + 2));
        end
    endtask

    task automatic rand_run(input int cnt);
        for (int i = 0; i < cnt; i++)
            issue($urandom_range(0, 5), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), $urandom(), $urandom_range(0, 3), 1'b0);
    endtask

    task automatic chk_halt(input logic exp_trap);
        repeat (3) @(negedge clk);
        chk("halt", 32'(halt), 32'd1);
        chk("trap", 32'(trap), 32'(exp_trap));
        chk("halt_pc", pc, mpc);
        chk("halt_if_valid", 32'(if_valid), 32'd0);
        chk("halt_commit", 32'(commit), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ill[4];
        int t0, n;
        ill[0] = 32'h00A0_8000;
        ill[1] = 32'h4020_81B3;
        ill[2] = 32'h0010_9093;
        ill[3] = 32'h0000_0073;
        if_ready = 1'b0;
        if_inst  = '0;

        do_reset();
        issue(0, 5'd1, 5'd0, 5'd0, 32'd5, 0, 1'b1);
        chk("t1_x1_5", alu_result, 32'd5);
        issue(0, 5'd1, 5'd1, 5'd0, 32'hFFF, 0, 1'b1);
        chk("t1_x1_4", alu_result, 32'd4);
        fetch(EBRK, 0, t0, n);
        chk_halt(1'b0);
        chk("t1_pc", pc, RPC + 32'd8);
        chk("t1_res_hold", alu_result, 32'd4);
        chk("e16_halt", 32'(halt16), 32'd1);
        chk("e16_trap", 32'(trap16), 32'd1);
        chk("e16_pc", pc16, RPC + 32'd4);
        chk("e16_commits", 32'(c16), 32'd1);

        do_reset();
        issue(0, 5'd1, 5'd0, 5'd0, 32'd7, 0, 1'b1);
        issue(0, 5'd2, 5'd0, 5'd0, 32'd9, 1, 1'b1);
        issue(1, 5'd3, 5'd1, 5'd2, 32'd0, 0, 1'b1);
        chk("t2_add", alu_result, 32'd16);
        issue(1, 5'd0, 5'd1, 5'd2, 32'd0, 0, 1'b1);
        chk("t2_x0_res", alu_result, 32'd16);
        issue(1, 5'd4, 5'd0, 5'd3, 32'd0, 0, 1'b1);
        issue(1, 5'd5, 5'd0, 5'd0, 32'd0, 0, 1'b1);
        chk("t2_x0_zero", alu_result, 32'd0);
        issue(2, 5'd5, 5'd0, 5'd0, 32'h12345, 0, 1'b1);
        chk("t3_lui", alu_result, 32'h1234_5000);
        issue(3, 5'd6, 5'd0, 5'd0, 32'd1, 0, 1'b1);
        issue(0, 5'd7, 5'd0, 5'd0, 32'hFFF, 0, 1'b1);
        issue(0, 5'd7, 5'd7, 5'd0, 32'd1, 0, 1'b1);
        chk("t3_wrap", alu_result, 32'd0);
        issue(0, 5'd3, 5'd0, 5'd0, 32'd11, 4, 1'b1);

        do_reset();
        issue(4, 5'd1, 5'd0, 5'd0, 32'd16, 0, 1'b1);
        chk("t4_jal", alu_result, 32'h8000_0004);
        issue(5, 5'd1, 5'd1, 5'd0, 32'd3, 0, 1'b1);
        chk("t4_jalr", alu_result, 32'h8000_0014);
        issue(5, 5'd0, 5'd0, 5'd0, 32'hFFC, 0, 1'b1);
        issue(0, 5'd2, 5'd0, 5'd0, 32'd1, 0, 1'b1);
        issue(0, 5'd2, 5'd2, 5'd0, 32'd1, 0, 1'b1);
        chk("t4_pc_wrap", pc, 32'd0);

        rand_run(300);

        fetch({12'd9, 5'd0, 3'b000, 5'd1, 7'b0010011}, 0, t0, n);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_no_commit", 32'(commit), 32'd0);
        chk("t6_pc", pc, RPC);
        do_reset();
        issue(1, 5'd2, 5'd1, 5'd0, 32'd0, 0, 1'b1);
        chk("t6_x1_zero", alu_result, 32'd0);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            rand_run(3);
            fetch(ill[i], $urandom_range(0, 2), t0, n);
            chk_halt(1'b1);
        end

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
